keypad_scan_debounce: RTL and testbench
=======================================

// Module: keypad_scan_debounce
// PURPOSE
//  Scans the 4x4 matrix keypad and debounces it. Produces pad_key/pad_pressed for the game-state FSM
//  (movement and rotation) and a one-cycle pad_strobe. Sits between the board keypad pins and the game
//  controller. Runs entirely on clk_40M; the controller samples pad_key and pad_pressed as levels.
// PARAMETERS
//  SCAN_DIV        40000  clk_40M cycles per column slot (1 ms); minimum 4
//  DEBOUNCE_SCANS  5      consecutive identical full scans (4 slots each) needed to accept a press or release; minimum 1
// PORTS
//  clk_40M      in   1  system clock
//  rst          in   1  reset, asynchronous, active-high
//  pad_row      in   4  keypad rows, active-low, externally pulled up, asynchronous
//  pad_col      out  4  column drive; exactly one bit low at a time
//  pad_key      out  4  debounced key code, one of the `KEY_* values
//  pad_pressed  out  1  high while the debounced key is held
//  pad_strobe   out  1  one-cycle pulse when pad_pressed rises
// BEHAVIOUR
//  Reset values: pad_col=4'b1110, pad_key=4'h0, pad_pressed=0, pad_strobe=0, FSM=IDLE, all counters 0.
//  Reset mid-scan or mid-debounce clears everything at once. pad_pressed drops asynchronously.
//  Scan: slot counter counts 0..SCAN_DIV-1. At wrap, pad_col rotates the low bit col0->col1->col2->col3->col0.
//   pad_row passes through a 2-FF synchroniser. Rows are sampled on the last cycle of each slot (slot==SCAN_DIV-1).
//   At the end of the col3 slot, scan_done pulses for 1 cycle. scan result = NONE, ONE(code) or MULTI(code).
//   The MULTI code is the first key in scan order: col0 row0..row3, then col1, and so on.
//  Legend (row,col): r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D.
//  FSM state changes happen only on scan_done:
//   IDLE:     ONE(k)  -> DEB_PRESS, cand=k, cnt=1.
//   DEB_PRESS: same k -> cnt+1. If cnt+1==DEBOUNCE_SCANS -> PRESSED: pad_key<=cand, pad_pressed<=1, pad_strobe=1 for 1 cycle.
//             different ONE(j) -> restart: cand=j, cnt=1. NONE -> IDLE.
//   PRESSED:  same pad_key -> stay. Anything else -> DEB_REL, cnt=1.
//   DEB_REL:  same pad_key reappears -> PRESSED, no new strobe. Otherwise cnt+1.
//             If cnt+1==DEBOUNCE_SCANS -> IDLE, pad_pressed<=0.
//  DEBOUNCE_SCANS=1: accept on the first qualifying scan. DEB_PRESS and DEB_REL are then transient and never held.
//  pad_key holds its last accepted code after release. It changes only on the PRESSED entry cycle.
//  Latency: a key held stable from the start of a scan asserts pad_pressed and pad_strobe 1 cycle after
//   the DEBOUNCE_SCANS-th scan_done.
//  Counters: slot is $clog2(SCAN_DIV) bits. cnt is $clog2(DEBOUNCE_SCANS+1) bits and saturates, no wrap.
// CONFIGURATION
//  KEYPAD_GHOST_REJECT_EN defined:  a MULTI scan is treated as NONE. Held chords never register,
//   and pressing a second key while PRESSED starts release debounce.
//  KEYPAD_GHOST_REJECT_EN undefined: a MULTI scan is treated as ONE(first key in scan order).
// STRUCTURE
//  global.v (shared): `KEY_0..`KEY_F codes, the row/col-to-code legend function, and scan result enum
//   SCAN_NONE/ONE/MULTI.
//  Sub-module keypad_col_scanner: slot counter, pad_col rotation, row synchroniser, sampling, and
//   scan result/code/scan_done.
//  The top holds the debounce FSM, output registers and strobe.
// TESTING  (SCAN_DIV=4, DEBOUNCE_SCANS=3 -> 16 cycles per scan)
//  1. Hold row1 low while col0 is driven, stable for 4 scans -> pad_pressed=1 and pad_key=`KEY_4
//     1 cycle after the 3rd scan_done, with exactly one pad_strobe. Release -> pad_pressed=0 after 3 empty scans.
//  2. Press bounces: present/absent on alternate scans for 6 scans -> pad_pressed stays 0 and no strobe.
//  3. In PRESSED on `KEY_7: one empty scan, then `KEY_7 again -> pad_pressed stays 1, no second strobe, pad_key=`KEY_7.
//  4. Hold `KEY_1 and `KEY_0 together for 5 scans -> with macro: pad_pressed=0.
//     Without macro: pad_key=`KEY_1, pad_pressed=1.
//  5. Assert rst during DEB_PRESS (cnt=2) and during PRESSED -> all outputs at reset values immediately.
//     After release, a full 3-scan debounce is needed again.
//  6. Idle keypad for 10 scans -> pad_col cycles 1110,1101,1011,0111 every 4 cycles, no output activity.

Source files
------------

// File: rtl/keypad_scan_debounce_pkg.sv
// Shared keypad definitions: key codes, the row/column legend and the scan result encoding.
package keypad_scan_debounce_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  typedef enum logic [1:0] {
    SCAN_NONE  = 2'd0,
    SCAN_ONE   = 2'd1,
    SCAN_MULTI = 2'd2
  } scan_result_e;

  // Board legend: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = 0 F E D.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = KEY_1;
      4'h1:    code = KEY_2;
      4'h2:    code = KEY_3;
      4'h3:    code = KEY_A;
      4'h4:    code = KEY_4;
      4'h5:    code = KEY_5;
      4'h6:    code = KEY_6;
      4'h7:    code = KEY_B;
      4'h8:    code = KEY_7;
      4'h9:    code = KEY_8;
      4'hA:    code = KEY_9;
      4'hB:    code = KEY_C;
      4'hC:    code = KEY_0;
      4'hD:    code = KEY_F;
      4'hE:    code = KEY_E;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Column scanner: drives one column low per slot, synchronises the rows and
// condenses each full 4-column pass into a scan result with a one-cycle scan_done.
module keypad_col_scanner
  import keypad_scan_debounce_pkg::*;
#(
  parameter int SCAN_DIV = 40000
) (
  input  logic         clk_40M,
  input  logic         rst,
  input  logic [3:0]   pad_row,
  output logic [3:0]   pad_col,
  output logic         scan_done_o,
  output scan_result_e scan_res_o,
  output logic [3:0]   scan_code_o
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

  logic [SW-1:0] slot_q;
  logic [3:0]    col_q;
  logic [1:0]    col_idx_q;
  logic [3:0]    row_meta_q, row_sync_q;
  logic          found_q, multi_q;
  logic [3:0]    code_q;
  logic          done_q;
  scan_result_e  res_q;
  logic [3:0]    rcode_q;

  logic [3:0] rows_low;
  logic [1:0] first_row;
  logic       col_any, col_multi;
  logic       acc_found, acc_multi;
  logic [3:0] acc_code;

  always_comb begin
    rows_low  = ~row_sync_q;
    col_any   = |rows_low;
    col_multi = (rows_low & (rows_low - 4'd1)) != 4'd0;
    if (rows_low[0])      first_row = 2'd0;
    else if (rows_low[1]) first_row = 2'd1;
    else if (rows_low[2]) first_row = 2'd2;
    else                  first_row = 2'd3;
    // Earlier columns win, so the first hit of the pass fixes the reported code.
    acc_found = found_q | col_any;
    acc_multi = multi_q | col_multi | (found_q & col_any);
    acc_code  = found_q ? code_q : key_code(first_row, col_idx_q);
  end

  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      slot_q     <= '0;
      col_q      <= 4'b1110;
      col_idx_q  <= 2'd0;
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      found_q    <= 1'b0;
      multi_q    <= 1'b0;
      code_q     <= 4'h0;
      done_q     <= 1'b0;
      res_q      <= SCAN_NONE;
      rcode_q    <= 4'h0;
    end else begin
      row_meta_q <= pad_row;
      row_sync_q <= row_meta_q;
      done_q     <= 1'b0;
      if (slot_q == SLOT_LAST) begin
        slot_q    <= '0;
        col_q     <= {col_q[2:0], col_q[3]};
        col_idx_q <= col_idx_q + 2'd1;
        if (col_idx_q == 2'd3) begin
          done_q  <= 1'b1;
          res_q   <= !acc_found ? SCAN_NONE : (acc_multi ? SCAN_MULTI : SCAN_ONE);
          rcode_q <= acc_found ? acc_code : 4'h0;
          found_q <= 1'b0;
          multi_q <= 1'b0;
          code_q  <= 4'h0;
        end else begin
          found_q <= acc_found;
          multi_q <= acc_multi;
          code_q  <= acc_code;
        end
      end else begin
        slot_q <= slot_q + SW'(1);
      end
    end
  end

  assign pad_col     = col_q;
  assign scan_done_o = done_q;
  assign scan_res_o  = res_q;
  assign scan_code_o = rcode_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scanner with press/release debounce and press strobe.
// Define KEYPAD_GHOST_REJECT_EN to treat multi-key scans as no key pressed.
module keypad_scan_debounce
  import keypad_scan_debounce_pkg::*;
#(
  parameter int SCAN_DIV       = 40000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic       clk_40M,
  input  logic       rst,
  input  logic [3:0] pad_row,
  output logic [3:0] pad_col,
  output logic [3:0] pad_key,
  output logic       pad_pressed,
  output logic       pad_strobe
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_SCANS);
  localparam bit DEB_ONE = (DEBOUNCE_SCANS == 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DEB_PRESS = 2'd1;
  localparam logic [1:0] ST_PRESSED   = 2'd2;
  localparam logic [1:0] ST_DEB_REL   = 2'd3;

  logic         scan_done;
  scan_result_e scan_res;
  logic [3:0]   scan_code;

  keypad_col_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
    .clk_40M     (clk_40M),
    .rst         (rst),
    .pad_row     (pad_row),
    .pad_col     (pad_col),
    .scan_done_o (scan_done),
    .scan_res_o  (scan_res),
    .scan_code_o (scan_code)
  );

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d, key_q, key_d;
  logic          pressed_q, pressed_d, strobe_q, strobe_d;
  logic          eff_valid, hit_key, hit_cand;

  always_comb begin
`ifdef KEYPAD_GHOST_REJECT_EN
    eff_valid = (scan_res == SCAN_ONE);
`else
    eff_valid = (scan_res != SCAN_NONE);
`endif
    hit_key  = eff_valid && (scan_code == key_q);
    hit_cand = eff_valid && (scan_code == cand_q);
    cnt_inc  = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + CW'(1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    key_d     = key_q;
    pressed_d = pressed_q;
    strobe_d  = 1'b0;
    if (scan_done) begin
      case (state_q)
        ST_IDLE: begin
          if (eff_valid) begin
            cand_d = scan_code;
            if (DEB_ONE) begin
              state_d   = ST_PRESSED;
              key_d     = scan_code;
              pressed_d = 1'b1;
              strobe_d  = 1'b1;
              cnt_d     = '0;
            end else begin
              state_d = ST_DEB_PRESS;
              cnt_d   = CW'(1);
            end
          end
        end
        ST_DEB_PRESS: begin
          if (!eff_valid) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (hit_cand) begin
            if (cnt_inc == DEB_MAX) begin
              state_d   = ST_PRESSED;
              key_d     = cand_q;
              pressed_d = 1'b1;
              strobe_d  = 1'b1;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cand_d = scan_code;
            cnt_d  = CW'(1);
          end
        end
        ST_PRESSED: begin
          if (!hit_key) begin
            if (DEB_ONE) begin
              state_d   = ST_IDLE;
              pressed_d = 1'b0;
              cnt_d     = '0;
            end else begin
              state_d = ST_DEB_REL;
              cnt_d   = CW'(1);
            end
          end
        end
        default: begin
          // Reappearance of the held key cancels the release without a new strobe.
          if (hit_key) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == DEB_MAX) begin
            state_d   = ST_IDLE;
            pressed_d = 1'b0;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cand_q    <= 4'h0;
      key_q     <= 4'h0;
      pressed_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      key_q     <= key_d;
      pressed_q <= pressed_d;
      strobe_q  <= strobe_d;
    end
  end

  assign pad_key     = key_q;
  assign pad_pressed = pressed_q;
  assign pad_strobe  = strobe_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16 cycles per scan).
module tb_keypad_scan_debounce;

  localparam int SD = 4;
  localparam int DS = 3;
  localparam int SCAN_CYC = 4 * SD;

  logic       clk_40M = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] pad_row;
  logic [3:0] pad_col;
  logic [3:0] pad_key;
  logic       pad_pressed;
  logic       pad_strobe;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [15:0] keys = 16'h0;
  logic [15:0] snap [0:255];
  int nscan = 0;
  logic [3:0] legend [16];

  logic       m_pressed = 1'b0;
  logic [3:0] m_key = 4'h0;
  logic [3:0] m_cand = 4'h0;
  int         m_run = 0;
  int         m_miss = 0;
  logic       exp_strobe = 1'b0;

  int   strobe_cnt = 0;
  int   last_rise = -1;
  int   last_fall = -1;
  logic prev_pressed = 1'b0;

  keypad_scan_debounce #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk_40M     (clk_40M),
    .rst         (rst),
    .pad_row     (pad_row),
    .pad_col     (pad_col),
    .pad_key     (pad_key),
    .pad_pressed (pad_pressed),
    .pad_strobe  (pad_strobe)
  );

  always #5 clk_40M = ~clk_40M;

  always @(posedge clk_40M or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Keypad physics: a held key pulls its row low while its column is driven low.
  always_comb begin
    pad_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !pad_col[c]) pad_row[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void eval_scan(input logic [15:0] k, output logic valid, output logic [3:0] code);
    int n;
    n = 0;
    code = 4'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[r*4+c]) begin
          if (n == 0) code = legend[r*4+c];
          n++;
        end
`ifdef KEYPAD_GHOST_REJECT_EN
    valid = (n == 1);
`else
    valid = (n >= 1);
`endif
  endfunction

  // Model: scan k's effect is visible in cycle 16k+17; compare every cycle.
  always @(negedge clk_40M) begin
    logic       v;
    logic [3:0] code;
    logic [3:0] exp_col;
    int         idx;
    exp_strobe = 1'b0;
    if (rst) begin
      m_pressed = 1'b0; m_key = 4'h0; m_cand = 4'h0; m_run = 0; m_miss = 0;
    end else if (cyc >= SCAN_CYC + 1 && (cyc - SCAN_CYC - 1) % SCAN_CYC == 0) begin
      idx = (cyc - SCAN_CYC - 1) / SCAN_CYC;
      if (idx < nscan && idx < 256) begin
        eval_scan(snap[idx], v, code);
        if (!m_pressed) begin
          if (v) begin
            if (m_run > 0 && code == m_cand) m_run++;
            else begin m_cand = code; m_run = 1; end
          end else m_run = 0;
          if (m_run == DS) begin
            m_pressed = 1'b1; m_key = m_cand; exp_strobe = 1'b1; m_run = 0; m_miss = 0;
          end
        end else begin
          if (v && code == m_key) m_miss = 0;
          else m_miss++;
          if (m_miss == DS) begin m_pressed = 1'b0; m_miss = 0; m_run = 0; end
        end
      end
    end
    exp_col = 4'hF;
    exp_col[(cyc / SD) % 4] = 1'b0;
    chk("pad_col", {28'd0, pad_col}, {28'd0, exp_col});
    chk("pad_pressed", {31'd0, pad_pressed}, {31'd0, m_pressed});
    chk("pad_key", {28'd0, pad_key}, {28'd0, m_key});
    chk("pad_strobe", {31'd0, pad_strobe}, {31'd0, exp_strobe});
    if (pad_strobe) strobe_cnt++;
    if (!rst) begin
      if (pad_pressed && !prev_pressed) last_rise = cyc;
      if (!pad_pressed && prev_pressed) last_fall = cyc;
    end
    prev_pressed = rst ? 1'b0 : pad_pressed;
  end

  task automatic do_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_pressed", {31'd0, pad_pressed}, 32'd0);
    chk("rst_strobe", {31'd0, pad_strobe}, 32'd0);
    chk("rst_key", {28'd0, pad_key}, 32'd0);
    chk("rst_col", {28'd0, pad_col}, 32'h0000000E);
    repeat (2) @(negedge clk_40M);
    #2;
    rst = 1'b0;
    nscan = 0;
    last_rise = -1;
    last_fall = -1;
  endtask

  task automatic scan(input logic [15:0] k);
    keys = k;
    if (nscan < 256) snap[nscan] = k;
    nscan++;
    repeat (SCAN_CYC) @(posedge clk_40M);
    #1;
  endtask

  task automatic partial_then_reset(input logic [15:0] k, input int n);
    keys = k;
    if (nscan < 256) snap[nscan] = k;
    nscan++;
    repeat (n) @(posedge clk_40M);
    do_reset();
  endtask

  localparam logic [15:0] K1 = 16'h0001;
  localparam logic [15:0] K4 = 16'h0010;
  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] K7 = 16'h0100;
  localparam logic [15:0] K0 = 16'h1000;

  initial begin
    int s0;
    logic [15:0] cur;
    legend = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

    // 1: press KEY_4 (row1,col0), then release
    do_reset();
    s0 = strobe_cnt;
    repeat (4) scan(K4);
    chk("t1_rise_cycle", last_rise, 49);
    chk("t1_key", {28'd0, pad_key}, 32'h4);
    chk("t1_strobes", strobe_cnt - s0, 1);
    repeat (4) scan(16'h0);
    chk("t1_fall_cycle", last_fall, 113);
    chk("t1_key_held", {28'd0, pad_key}, 32'h4);

    // 2: bouncing press never accepted
    do_reset();
    s0 = strobe_cnt;
    repeat (3) begin scan(K4); scan(16'h0); end
    scan(16'h0);
    chk("t2_strobes", strobe_cnt - s0, 0);
    chk("t2_rise", last_rise, -1);

    // 3: KEY_7 with a one-scan dropout
    do_reset();
    s0 = strobe_cnt;
    repeat (3) scan(K7);
    scan(16'h0);
    repeat (2) scan(K7);
    chk("t3_pressed", {31'd0, pad_pressed}, 32'd1);
    chk("t3_key", {28'd0, pad_key}, 32'h7);
    chk("t3_strobes", strobe_cnt - s0, 1);
    chk("t3_fall", last_fall, -1);

    // 4: chord KEY_1 + KEY_0
    do_reset();
    repeat (5) scan(K1 | K0);
`ifdef KEYPAD_GHOST_REJECT_EN
    chk("t4_pressed", {31'd0, pad_pressed}, 32'd0);
`else
    chk("t4_pressed", {31'd0, pad_pressed}, 32'd1);
    chk("t4_key", {28'd0, pad_key}, 32'h1);
`endif

    // 5: reset during DEB_PRESS and during PRESSED
    do_reset();
    repeat (2) scan(K5);
    partial_then_reset(K5, 8);
    repeat (4) scan(K5);
    chk("t5_rise_after_rst", last_rise, 49);
    chk("t5_pre_pressed", {31'd0, pad_pressed}, 32'd1);
    partial_then_reset(K5, 8);
    repeat (2) scan(K5);
    chk("t5_not_yet", {31'd0, pad_pressed}, 32'd0);
    repeat (2) scan(K5);
    chk("t5_rise_again", last_rise, 49);
    chk("t5_key", {28'd0, pad_key}, 32'h5);

    // 6: idle keypad
    do_reset();
    s0 = strobe_cnt;
    repeat (10) scan(16'h0);
    chk("t6_strobes", strobe_cnt - s0, 0);
    chk("t6_rise", last_rise, -1);

    // Random scans: hold previous set, release, single key or two-key chord
    do_reset();
    cur = 16'h0;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2:       cur = 16'h0;
          3, 4, 5, 6, 7: cur = 16'h1 << $urandom_range(0, 15);
          default:       cur = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        endcase
      end
      scan(cur);
    end
    repeat (3) @(posedge clk_40M);
    @(negedge clk_40M);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
